// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared state encodings and widths for the UART program loader
package uart_prog_loader_pkg;

    localparam int ADR_W  = 15;
    localparam int WIDX_W = 14;

    localparam logic SEG_INST = 1'b0;
    localparam logic SEG_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_HDR_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } upg_state_e;

endpackage

// File: rtl/uart_prog_loader_timeout_ctr.sv
// rtl/uart_prog_loader_timeout_ctr.sv - inter-byte idle timeout counter
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear_i     restart the count (byte received, restart, or not busy)
//   enable_i    count while the loader is mid-frame
//   expired_o   count has reached TIMEOUT_CYC-1 and is not being cleared
module upg_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYC - 1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART byte stream to instruction/data RAM word writes
// Optional feature macro: UPG_CHECKSUM_EN (per-segment XOR checksum byte).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      pulse: enter programming at segment 0 (restarts if busy)
//   rx_valid_i   strobe: rx_data_i holds a received byte
//   rx_data_i    received byte
//   upg_wen_o    1-cycle RAM write strobe
//   upg_adr_o    {segment, word index}
//   upg_dat_o    assembled little-endian word
//   upg_done_o   both segments written; held until next start
//   upg_err_o    bad count, timeout or checksum failure
//   busy_o       a frame is in progress
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int MAX_WORDS   = 16384,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             upg_err_o,
    output logic             busy_o
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    upg_state_e        state_q, state_d;
    upg_state_e        seg_end_st, pay_end_st;
    logic              seg_q;
    logic [15:0]       n_q;
    logic [23:0]       word_q;
    logic [1:0]        byte_idx_q;
    logic [WIDX_W-1:0] word_idx_q;
    logic              wen_q;
    logic [ADR_W-1:0]  adr_q;
    logic [31:0]       dat_q;
    logic              done_q;
    logic              tmo_expired;
    logic              rx_ok;
    logic              last_byte;
    logic              last_word;
    logic [15:0]       hdr_n;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    // A byte coinciding with start_i belongs to the aborted frame and is dropped.
    assign rx_ok     = rx_valid_i && !start_i && busy_o;
    assign last_byte = (byte_idx_q == 2'd3);
    assign last_word = ({2'b00, word_idx_q} == (n_q - 16'd1));
    assign hdr_n     = {rx_data_i, n_q[7:0]};

    upg_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (rx_valid_i || start_i),
        .enable_i  (busy_o),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        seg_end_st = seg_q ? ST_DONE : ST_HDR_LO;
`ifdef UPG_CHECKSUM_EN
        pay_end_st = ST_CHK;
`else
        pay_end_st = seg_end_st;
`endif
        state_d = state_q;
        if (start_i) begin
            state_d = ST_HDR_LO;
        end else if (rx_ok) begin
            case (state_q)
                ST_HDR_LO: state_d = ST_HDR_HI;
                ST_HDR_HI: begin
                    if (hdr_n == 16'd0) begin
                        state_d = pay_end_st;
                    end else if ({1'b0, hdr_n} > MAX_N) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (last_byte && last_word) begin
                        state_d = pay_end_st;
                    end
                end
`ifdef UPG_CHECKSUM_EN
                ST_CHK: state_d = (rx_data_i == chk_q) ? seg_end_st : ST_ERR;
`endif
                default: state_d = state_q;
            endcase
        end else if (tmo_expired) begin
            state_d = ST_ERR;
        end
    end

    always_comb begin
        busy_o    = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
        upg_err_o = (state_q == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= SEG_INST;
            n_q        <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            if (start_i) begin
                seg_q      <= SEG_INST;
                n_q        <= '0;
                byte_idx_q <= '0;
                word_idx_q <= '0;
                done_q     <= 1'b0;
`ifdef UPG_CHECKSUM_EN
                chk_q      <= '0;
`endif
            end else begin
                // Registered from the state so done trails the final strobe by a cycle.
                done_q <= (state_q == ST_DONE);
                if (rx_ok) begin
`ifdef UPG_CHECKSUM_EN
                    chk_q <= chk_q ^ rx_data_i;
`endif
                    case (state_q)
                        ST_HDR_LO: n_q[7:0] <= rx_data_i;
                        ST_HDR_HI: begin
                            n_q[15:8]  <= rx_data_i;
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                        end
                        ST_PAYLOAD: begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            case (byte_idx_q)
                                2'd0: word_q[7:0]   <= rx_data_i;
                                2'd1: word_q[15:8]  <= rx_data_i;
                                2'd2: word_q[23:16] <= rx_data_i;
                                default: begin
                                    wen_q      <= 1'b1;
                                    adr_q      <= {seg_q, word_idx_q};
                                    dat_q      <= {rx_data_i, word_q};
                                    word_idx_q <= word_idx_q + WIDX_W'(1);
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
                // The only non-start entry into HDR_LO is the end of segment 0.
                if ((state_q != ST_HDR_LO) && (state_d == ST_HDR_LO)) begin
                    seg_q <= SEG_DATA;
`ifdef UPG_CHECKSUM_EN
                    chk_q <= '0;
`endif
                end
            end
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;

endmodule
